// File: rtl/farming_pkg.sv
// Shared definitions for the microgreen monitor front-end: sensor channel ids,
// the SPI ADC command encoding and the scan sequencer state type.
package farming_pkg;

    localparam logic [1:0] CH_SOIL  = 2'd0;
    localparam logic [1:0] CH_TEMP  = 2'd1;
    localparam logic [1:0] CH_HUMID = 2'd2;
    localparam logic [1:0] CH_LIGHT = 2'd3;

    // Start bit plus single-ended mode, sent ahead of the channel number
    localparam logic [1:0] ADC_CMD_START_SE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_XFER,
        ST_PRESENT
    } scan_state_t;

    function automatic logic [7:0] adc_command(input logic [1:0] ch);
        return {ADC_CMD_START_SE, ch, 4'b0000};
    endfunction

    // First set mask bit strictly after 'last', ascending with wrap 3->0
    function automatic logic [1:0] next_channel(input logic [1:0] last, input logic [3:0] mask);
        logic [1:0] result;
        logic [1:0] cand;
        logic       found;
        result = last;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!found && mask[cand]) begin
                result = cand;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_adc_master.sv
// SPI mode-0 master for the 4-channel ADC: one 16-SCLK frame per start pulse,
// 8 command bits out on MOSI followed by 8 data bits in from MISO.
module spi_adc_master
    import farming_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ena,
    input  logic       i_start,
    input  logic [1:0] i_ch,
    output logic       o_cs_n,
    output logic       o_sclk,
    output logic       o_mosi,
    input  logic       i_miso,
    output logic [7:0] o_rx_data,
    output logic       o_done
);

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             r_active;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_bitCnt;
    logic             r_sclk;
    logic             r_csN;
    logic             r_mosi;
    logic [7:0]       r_txSr;
    logic [7:0]       r_rxSr;
    logic [7:0]       w_cmd;
    logic             w_halfEnd;

    assign w_cmd     = adc_command(i_ch);
    assign w_halfEnd = r_active && (r_div == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_bitCnt <= '0;
            r_sclk   <= 1'b0;
            r_csN    <= 1'b1;
            r_mosi   <= 1'b0;
            r_txSr   <= '0;
            r_rxSr   <= '0;
        end else if (i_ena) begin
            if (!r_active) begin
                if (i_start) begin
                    r_active <= 1'b1;
                    r_csN    <= 1'b0;
                    r_div    <= '0;
                    r_bitCnt <= '0;
                    r_sclk   <= 1'b0;
                    r_mosi   <= w_cmd[7];
                    r_txSr   <= {w_cmd[6:0], 1'b0};
                    r_rxSr   <= '0;
                end
            end else if (!w_halfEnd) begin
                r_div <= r_div + 1'b1;
            end else begin
                r_div  <= '0;
                r_sclk <= ~r_sclk;
                if (!r_sclk) begin
                    if (r_bitCnt[3]) begin
                        r_rxSr <= {r_rxSr[6:0], i_miso};
                    end
                end else if (r_bitCnt == 5'd15) begin
                    r_active <= 1'b0;
                    r_csN    <= 1'b1;
                    r_mosi   <= 1'b0;
                end else begin
                    // MOSI advances on the falling edge; read half of the frame sends zeros
                    r_bitCnt <= r_bitCnt + 1'b1;
                    r_mosi   <= (r_bitCnt < 5'd7) ? r_txSr[7] : 1'b0;
                    r_txSr   <= {r_txSr[6:0], 1'b0};
                end
            end
        end
    end

    assign o_done    = i_ena && w_halfEnd && r_sclk && (r_bitCnt == 5'd15);
    assign o_cs_n    = r_csN;
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;
    assign o_rx_data = r_rxSr;

endmodule

// File: rtl/sensor_scan_sequencer.sv
// Round-robin scan of the masked ADC channels, presenting each 8-bit result
// with its channel number on a valid/ready handshake; pauses in camera mode.
module sensor_scan_sequencer
    import farming_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SCAN_GAP = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       scan_en,
    input  logic       camera_mode,
    input  logic [3:0] ch_mask,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_mosi,
    input  logic       adc_miso,
    output logic [7:0] sample_data,
    output logic [1:0] sample_ch,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       busy
);

    localparam int               GAP_W    = $clog2(SCAN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP);

    scan_state_t      r_state;
    scan_state_t      w_nextState;
    logic [GAP_W-1:0] r_gapCnt;
    logic [1:0]       r_ch;
    logic [7:0]       r_sampleData;
    logic [1:0]       r_sampleCh;
    logic             r_sampleValid;
    logic             w_startOk;
    logic             w_select;
    logic             w_accept;
    logic             w_spiStart;
    logic             w_spiDone;
    logic [7:0]       w_rxData;

    assign w_startOk  = scan_en && !camera_mode && (ch_mask != 4'b0000);
    assign w_accept   = (r_state == ST_PRESENT) && r_sampleValid && sample_ready;
    assign w_spiStart = (r_state == ST_GAP) && (r_gapCnt == GAP_LAST);

    always_comb begin
        w_nextState = r_state;
        w_select    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_startOk) begin
                    w_nextState = ST_GAP;
                    w_select    = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_spiStart) w_nextState = ST_XFER;
            end
            ST_XFER: begin
                if (w_spiDone) w_nextState = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (w_accept) begin
                    if (w_startOk) begin
                        w_nextState = ST_GAP;
                        w_select    = 1'b1;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Start conditions are only consulted at selection, so an in-flight frame always completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_gapCnt      <= '0;
            r_ch          <= CH_LIGHT;
            r_sampleData  <= '0;
            r_sampleCh    <= '0;
            r_sampleValid <= 1'b0;
        end else if (ena) begin
            r_state  <= w_nextState;
            r_gapCnt <= (r_state == ST_GAP && !w_spiStart) ? r_gapCnt + 1'b1 : '0;
            if (w_select) begin
                r_ch <= next_channel(r_ch, ch_mask);
            end
            if (r_state == ST_XFER && w_spiDone) begin
                r_sampleData  <= w_rxData;
                r_sampleCh    <= r_ch;
                r_sampleValid <= 1'b1;
            end else if (w_accept) begin
                r_sampleValid <= 1'b0;
            end
        end
    end

    spi_adc_master #(
        .CLK_DIV(CLK_DIV)
    ) u_spi (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_ena    (ena),
        .i_start  (w_spiStart),
        .i_ch     (r_ch),
        .o_cs_n   (adc_cs_n),
        .o_sclk   (adc_sclk),
        .o_mosi   (adc_mosi),
        .i_miso   (adc_miso),
        .o_rx_data(w_rxData),
        .o_done   (w_spiDone)
    );

    assign sample_data  = r_sampleData;
    assign sample_ch    = r_sampleCh;
    assign sample_valid = r_sampleValid;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sensor_scan_sequencer.sv
// Directed bench for sensor_scan_sequencer: behavioural SPI ADCs answer each frame,
// one task per scenario with hand-computed expectations.
module tb_sensor_scan_sequencer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       ena = 1'b1, scan_en = 1'b0, camera_mode = 1'b0, sample_ready = 1'b1;
    logic [3:0] ch_mask = 4'b1111;
    logic       adc_miso = 1'b0;
    logic       adc_cs_n, adc_sclk, adc_mosi, sample_valid, busy;
    logic [7:0] sample_data;
    logic [1:0] sample_ch;

    logic       enaB = 1'b1, scanEnB = 1'b0, readyB = 1'b1, misoB = 1'b0;
    logic [3:0] maskB = 4'b0001;
    logic       csNB, sclkB, mosiB, validB, busyB;
    logic [7:0] dataB;
    logic [1:0] chB;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    sensor_scan_sequencer #(.CLK_DIV(4), .SCAN_GAP(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .scan_en(scan_en), .camera_mode(camera_mode),
        .ch_mask(ch_mask), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi),
        .adc_miso(adc_miso), .sample_data(sample_data), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy)
    );

    sensor_scan_sequencer #(.CLK_DIV(1), .SCAN_GAP(2)) u_dutB (
        .clk(clk), .rst_n(rst_n), .ena(enaB), .scan_en(scanEnB), .camera_mode(1'b0),
        .ch_mask(maskB), .adc_cs_n(csNB), .adc_sclk(sclkB), .adc_mosi(mosiB),
        .adc_miso(misoB), .sample_data(dataB), .sample_ch(chB),
        .sample_valid(validB), .sample_ready(readyB), .busy(busyB)
    );

    // ADC model: latches the command, answers 0x40 + channel from the command it received
    int         mBits = 0;
    logic [7:0] mCmd = 8'h00, mLastCmd = 8'h00, mShift = 8'h00;
    logic       mPrevSclk = 1'b0, mPrevCs = 1'b1;
    always @(adc_cs_n or adc_sclk) begin
        if (mPrevCs && !adc_cs_n) begin
            mBits = 0;
            mCmd  = 8'h00;
        end
        if (!adc_cs_n && !mPrevSclk && adc_sclk) begin
            if (mBits < 8) mCmd = {mCmd[6:0], adc_mosi};
            mBits++;
            if (mBits == 8) mLastCmd = mCmd;
        end
        if (!adc_cs_n && mPrevSclk && !adc_sclk && mBits >= 8) begin
            if (mBits == 8) mShift = 8'h40 + {6'd0, mCmd[5:4]};
            adc_miso = mShift[7];
            mShift   = {mShift[6:0], 1'b0};
        end
        mPrevCs   = adc_cs_n;
        mPrevSclk = adc_sclk;
    end

    int         bBits = 0;
    logic [7:0] bShift = 8'h00;
    logic       bPrevSclk = 1'b0, bPrevCs = 1'b1;
    always @(csNB or sclkB) begin
        if (bPrevCs && !csNB) bBits = 0;
        if (!csNB && !bPrevSclk && sclkB) bBits++;
        if (!csNB && bPrevSclk && !sclkB && bBits >= 8) begin
            if (bBits == 8) bShift = 8'hA5;
            misoB  = bShift[7];
            bShift = {bShift[6:0], 1'b0};
        end
        bPrevCs   = csNB;
        bPrevSclk = sclkB;
    end

    task automatic waitValid(input int limit, output int cycles, output int csLow, output bit ok);
        cycles = 0;
        csLow  = 0;
        ok     = 1'b0;
        while (cycles < limit && !ok) begin
            @(posedge clk); #1;
            cycles++;
            if (adc_cs_n === 1'b0) csLow++;
            if (sample_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int idleErr = 0;
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if ({adc_cs_n, adc_sclk, adc_mosi, sample_valid, busy} !== 5'b10000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 10000", {adc_cs_n, adc_sclk, adc_mosi, sample_valid, busy});
        end
        testsRun++;
        if (sample_data !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got %h, expected 00", sample_data);
        end
        testsRun++;
        if (sample_ch !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ch: got %0d, expected 0", sample_ch);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || adc_cs_n !== 1'b1) idleErr++;
        end
        testsRun++;
        if (idleErr != 0) begin
            testsFailed++;
            $display("[TB] FAIL idle_without_scan_en: %0d bad cycles, expected 0", idleErr);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] expCh [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] expDat [5] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h40};
        logic [7:0] expCmd [5] = '{8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'hC0};
        int cyc, low;
        bit ok;
        scan_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            waitValid(400, cyc, low, ok);
            testsRun++;
            if (!ok || sample_ch !== expCh[k] || sample_data !== expDat[k]) begin
                testsFailed++;
                $display("[TB] FAIL rr_sample%0d: got ch %0d data %h (valid %b), expected ch %0d data %h", k, sample_ch, sample_data, ok, expCh[k], expDat[k]);
            end
            testsRun++;
            if (mLastCmd !== expCmd[k]) begin
                testsFailed++;
                $display("[TB] FAIL rr_mosi_cmd%0d: got %b, expected %b", k, mLastCmd, expCmd[k]);
            end
            testsRun++;
            if (cyc != 146 || low != 128) begin
                testsFailed++;
                $display("[TB] FAIL rr_timing%0d: got period %0d cs_low %0d, expected 146 and 128", k, cyc, low);
            end
        end
    endtask

    task automatic test_mask_change();
        logic [1:0] expCh [3] = '{2'd1, 2'd3, 2'd1};
        int cyc, low;
        bit ok;
        ch_mask = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            waitValid(400, cyc, low, ok);
            testsRun++;
            if (!ok || sample_ch !== expCh[k] || sample_data !== (8'h40 + {6'd0, expCh[k]})) begin
                testsFailed++;
                $display("[TB] FAIL mask1010_sample%0d: got ch %0d data %h, expected ch %0d", k, sample_ch, sample_data, expCh[k]);
            end
        end
        repeat (60) @(posedge clk);
        #1;
        ch_mask = 4'b0100;
        waitValid(400, cyc, low, ok);
        testsRun++;
        if (!ok || sample_ch !== 2'd3 || sample_data !== 8'h43) begin
            testsFailed++;
            $display("[TB] FAIL mask_change_inflight: got ch %0d data %h, expected ch 3 data 43", sample_ch, sample_data);
        end
        waitValid(400, cyc, low, ok);
        testsRun++;
        if (!ok || sample_ch !== 2'd2 || sample_data !== 8'h42) begin
            testsFailed++;
            $display("[TB] FAIL mask_change_next: got ch %0d data %h, expected ch 2 data 42", sample_ch, sample_data);
        end
    endtask

    task automatic test_backpressure();
        int holdErr = 0;
        int n = 0;
        sample_ready = 1'b0;
        repeat (500) begin
            @(posedge clk); #1;
            if ({sample_valid, sample_data, sample_ch, adc_cs_n, adc_sclk, busy} !== {1'b1, 8'h42, 2'd2, 1'b1, 1'b0, 1'b1})
                holdErr++;
        end
        testsRun++;
        if (holdErr != 0) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_hold: %0d bad cycles, expected 0", holdErr);
        end
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
        testsRun++;
        if (sample_valid !== 1'b0 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ready_pulse: got valid %b busy %b, expected valid 0 busy 1", sample_valid, busy);
        end
        do begin
            @(posedge clk); #1;
            n++;
        end while (adc_cs_n === 1'b1 && n < 100);
        testsRun++;
        if (n != 17) begin
            testsFailed++;
            $display("[TB] FAIL gap_length: got %0d cycles to CS_N low, expected 17", n);
        end
        sample_ready = 1'b1;
    endtask

    task automatic test_camera_mode();
        int cyc, low;
        int idleErr = 0;
        bit ok;
        ch_mask = 4'b1111;
        repeat (40) @(posedge clk);
        #1;
        camera_mode = 1'b1;
        waitValid(400, cyc, low, ok);
        testsRun++;
        if (!ok || sample_ch !== 2'd2 || sample_data !== 8'h42) begin
            testsFailed++;
            $display("[TB] FAIL camera_frame_completes: got ch %0d data %h, expected ch 2 data 42", sample_ch, sample_data);
        end
        @(posedge clk); #1;
        testsRun++;
        if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL camera_idle: got busy %b valid %b, expected 0 0", busy, sample_valid);
        end
        repeat (300) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || adc_cs_n !== 1'b1 || sample_valid !== 1'b0) idleErr++;
        end
        testsRun++;
        if (idleErr != 0) begin
            testsFailed++;
            $display("[TB] FAIL camera_suppress: %0d bad cycles, expected 0", idleErr);
        end
        camera_mode = 1'b0;
        waitValid(400, cyc, low, ok);
        testsRun++;
        if (!ok || sample_ch !== 2'd3 || sample_data !== 8'h43 || cyc != 146) begin
            testsFailed++;
            $display("[TB] FAIL camera_restart: got ch %0d data %h after %0d cycles, expected ch 3 data 43 after 146", sample_ch, sample_data, cyc);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc, low;
        int n = 0;
        bit ok;
        do begin
            @(posedge clk); #1;
            n++;
        end while (adc_cs_n === 1'b1 && n < 100);
        repeat (85) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({adc_cs_n, adc_sclk, adc_mosi, sample_valid, busy} !== 5'b10000 || sample_data !== 8'h00 || sample_ch !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_xfer: got ctrl %b data %h ch %0d, expected 10000 00 0", {adc_cs_n, adc_sclk, adc_mosi, sample_valid, busy}, sample_data, sample_ch);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        waitValid(400, cyc, low, ok);
        testsRun++;
        if (!ok || sample_ch !== 2'd0 || sample_data !== 8'h40 || cyc != 146) begin
            testsFailed++;
            $display("[TB] FAIL reset_restart: got ch %0d data %h after %0d cycles, expected ch 0 data 40 after 146", sample_ch, sample_data, cyc);
        end
    endtask

    task automatic test_ena_freeze();
        int n = 0;
        int lowCnt = 1;
        int frozenErr = 0;
        logic [4:0] snap;
        scanEnB = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (csNB === 1'b1 && n < 100);
        testsRun++;
        if (n != 4) begin
            testsFailed++;
            $display("[TB] FAIL div1_start_latency: got %0d cycles, expected 4", n);
        end
        repeat (5) begin
            @(posedge clk); #1;
            if (csNB === 1'b0) lowCnt++;
        end
        enaB = 1'b0;
        snap = {csNB, sclkB, mosiB, validB, busyB};
        repeat (20) begin
            @(posedge clk); #1;
            if ({csNB, sclkB, mosiB, validB, busyB} !== snap) frozenErr++;
            if (csNB === 1'b0) lowCnt++;
        end
        enaB = 1'b1;
        n = 0;
        while (validB !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (csNB === 1'b0) lowCnt++;
        end
        testsRun++;
        if (frozenErr != 0) begin
            testsFailed++;
            $display("[TB] FAIL ena_freeze: %0d changed cycles, expected 0", frozenErr);
        end
        testsRun++;
        if (validB !== 1'b1 || dataB !== 8'hA5 || chB !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL ena_resume_data: got valid %b data %h ch %0d, expected 1 a5 0", validB, dataB, chB);
        end
        testsRun++;
        if (lowCnt != 52) begin
            testsFailed++;
            $display("[TB] FAIL ena_resume_length: got CS_N low %0d cycles, expected 52", lowCnt);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_mask_change();
        test_backpressure();
        test_camera_mode();
        test_reset_mid_frame();
        test_ena_freeze();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
